sobel_acc: RTL

Edge-detection accelerator. It reads an 8-bit grayscale image from port a of the shared dual-port memory and computes a 3×3 Sobel magnitude for every pixel. It writes the resulting image back to the same memory, after the input image. It sits between the debounced start button and memory port a, beside the UART/controller path that loads and unloads the memory on port b.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_kernel.sv | 38 +++
 rtl/sobel_acc.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge-detection accelerator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sobel_pkg;

  typedef logic [7:0]  pixel_t;
  typedef logic [31:0] word_t;

  // R0..R3 are the fetch sub-sequence, shared by the prime and step phases;
  // the accelerator keeps a separate flag to tell the two phases apart.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BORDER,
    ST_R0,
    ST_R1,
    ST_R2,
    ST_R3,
    ST_WR,
    ST_DONE
  } state_t;

  // Magnitude scaling: (|Gx| + |Gy|) >> SOBEL_SHIFT always fits in a pixel.
  localparam int unsigned SOBEL_SHIFT = 3;

endpackage

// File: rtl/sobel_kernel.sv
// One-pixel 3x3 Sobel magnitude, (|Gx| + |Gy|) >> 3.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: tl..br are the nine window pixels (row letter t/m/b, column l/c/r);
// mag is the output pixel.
module sobel_kernel
  import sobel_pkg::*;
(
  input  pixel_t tl, tc, tr,
  input  pixel_t ml, mc, mr,
  input  pixel_t bl, bc, br,
  output pixel_t mag
);

  logic [9:0]  gx_pos, gx_neg, gy_pos, gy_neg;
  logic [10:0] gx, gy, ax, ay, sum;
  logic        unused_mc;

  // The centre pixel carries no weight in either gradient.
  assign unused_mc = ^mc;

  assign gx_pos = {2'b00, tr} + {1'b0, mr, 1'b0} + {2'b00, br};
  assign gx_neg = {2'b00, tl} + {1'b0, ml, 1'b0} + {2'b00, bl};
  assign gy_pos = {2'b00, bl} + {1'b0, bc, 1'b0} + {2'b00, br};
  assign gy_neg = {2'b00, tl} + {1'b0, tc, 1'b0} + {2'b00, tr};

  // Differences lie in -1020..1020, so 11-bit two's complement is exact.
  assign gx = {1'b0, gx_pos} - {1'b0, gx_neg};
  assign gy = {1'b0, gy_pos} - {1'b0, gy_neg};

  assign ax = gx[10] ? (~gx + 11'd1) : gx;
  assign ay = gy[10] ? (~gy + 11'd1) : gy;

  // At most 2040, so the shifted result needs no clamp.
  assign sum = ax + ay;
  assign mag = pixel_t'(sum >> SOBEL_SHIFT);

endmodule

// File: rtl/sobel_acc.sv
// Sobel edge accelerator: reads an image on memory port a, writes magnitudes after it.
// Latency: W cycles per border row, 4 + 5*(W-1) + 1 cycles per interior row.
// Backpressure: none; memory port a is assumed always ready with 1-cycle read latency.
// Ports: clk, reset (async active-low), start (level request), addr/dataR/dataW/en/we
// (memory port a, 4 pixels per word, leftmost pixel in bits 7:0), finish (high in DONE).
module sobel_acc
  import sobel_pkg::*;
#(
  parameter int WIDTH    = 352,
  parameter int HEIGHT   = 288,
  parameter int OUT_BASE = WIDTH * HEIGHT / 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] addr,
  input  logic [31:0] dataR,
  output logic [31:0] dataW,
  output logic        en,
  output logic        we,
  output logic        finish
);

  localparam logic [15:0] W        = 16'(WIDTH / 4);
  localparam logic [15:0] W_LAST   = 16'(WIDTH / 4 - 1);
  localparam logic [15:0] OBASE    = 16'(OUT_BASE);
  localparam logic [15:0] ROW_LAST = 16'(HEIGHT - 2);  // last interior row
  localparam logic [15:0] ROW_BOT  = 16'(HEIGHT - 1);

  state_t      state;
  logic        priming;   // R0..R3 are fetching column 0 for a fresh row
  logic [15:0] row;       // current row index
  logic [15:0] col;       // output word column being produced
  logic [15:0] row_addr;  // row * W, word address of the current row's column 0
  logic [15:0] fcol;      // column fetched by R0..R2
  logic [15:0] wcol;      // column whose result is registered on this edge

  // Window [row][col]: row 0/1/2 = top/mid/bot, col 0/1/2 = left/centre/right.
  word_t win_q [3][3];
  word_t win_d [3][3];
  logic [47:0] strip [3];
  word_t kout, out_word;

  assign fcol = priming ? col : col + 16'd1;
  assign wcol = (state == ST_WR) ? col + 16'd1 : col;

  // Next-window view. The kernels look at this rather than win_q so that the
  // result for a column can be registered on the same edge that completes it
  // (bot capture in R3, or the shift on the back-to-back last-column write).
  always_comb begin
    win_d = win_q;
    case (state)
      ST_R1: win_d[0][2] = dataR;
      ST_R2: win_d[1][2] = dataR;
      ST_R3: begin
        if (priming) begin
          // Column 0 lands straight in the centre; left and right start empty.
          for (int r = 0; r < 3; r++) begin
            win_d[r][0] = '0;
            win_d[r][2] = '0;
          end
          win_d[0][1] = win_q[0][2];
          win_d[1][1] = win_q[1][2];
          win_d[2][1] = dataR;
        end else begin
          win_d[2][2] = dataR;
        end
      end
      ST_WR: begin
        // Shift left; the right slot stays zero for the last column.
        for (int r = 0; r < 3; r++) begin
          win_d[r][0] = win_q[r][1];
          win_d[r][1] = win_q[r][2];
          win_d[r][2] = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  // Each row strip is: right word byte 0, the centre word, left word byte 3.
  for (genvar r = 0; r < 3; r++) begin : g_strip
    assign strip[r] = {win_d[r][2][7:0], win_d[r][1], win_d[r][0][31:24]};
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    sobel_kernel u_kernel (
      .tl (strip[0][8*k      +: 8]),
      .tc (strip[0][8*k + 8  +: 8]),
      .tr (strip[0][8*k + 16 +: 8]),
      .ml (strip[1][8*k      +: 8]),
      .mc (strip[1][8*k + 8  +: 8]),
      .mr (strip[1][8*k + 16 +: 8]),
      .bl (strip[2][8*k      +: 8]),
      .bc (strip[2][8*k + 8  +: 8]),
      .br (strip[2][8*k + 16 +: 8]),
      .mag(kout[8*k +: 8])
    );
  end

  // Pixel x=0 and x=WIDTH-1 are border pixels and are forced to zero.
  always_comb begin
    out_word = kout;
    if (wcol == 16'd0)  out_word[7:0]   = '0;
    if (wcol == W_LAST) out_word[31:24] = '0;
  end

  // Memory outputs are registered: each transition presents the access of
  // the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      priming  <= 1'b0;
      row      <= '0;
      col      <= '0;
      row_addr <= '0;
      addr     <= '0;
      dataW    <= '0;
      en       <= 1'b0;
      we       <= 1'b0;
      finish   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          en <= 1'b0;
          we <= 1'b0;
          if (start) begin
            state    <= ST_BORDER;
            row      <= '0;
            col      <= '0;
            row_addr <= '0;
            addr     <= OBASE;
            dataW    <= '0;
            en       <= 1'b1;
            we       <= 1'b1;
          end
        end
        ST_BORDER: begin
          if (col == W_LAST) begin
            col <= '0;
            if (row == 16'd0) begin
              // Prime row 1: its top row is row 0, at row_addr.
              state    <= ST_R0;
              priming  <= 1'b1;
              row      <= 16'd1;
              row_addr <= W;
              addr     <= row_addr;
              we       <= 1'b0;
            end else begin
              state  <= ST_DONE;
              en     <= 1'b0;
              we     <= 1'b0;
              finish <= 1'b1;
            end
          end else begin
            col  <= col + 16'd1;
            addr <= addr + 16'd1;
          end
        end
        ST_R0: begin
          state <= ST_R1;
          addr  <= row_addr + fcol;
        end
        ST_R1: begin
          state <= ST_R2;
          addr  <= row_addr + W + fcol;
        end
        ST_R2: begin
          state <= ST_R3;
          en    <= 1'b0;
        end
        ST_R3: begin
          en <= 1'b1;
          if (priming) begin
            priming <= 1'b0;
            state   <= ST_R0;
            addr    <= row_addr - W + col + 16'd1;
          end else begin
            state <= ST_WR;
            we    <= 1'b1;
            addr  <= OBASE + row_addr + col;
            dataW <= out_word;
          end
        end
        ST_WR: begin
          if (col == W_LAST) begin
            col      <= '0;
            row_addr <= row_addr + W;
            if (row == ROW_LAST) begin
              state <= ST_BORDER;
              row   <= ROW_BOT;
              addr  <= OBASE + row_addr + W;
              dataW <= '0;
            end else begin
              // Next row's top is the current row.
              state   <= ST_R0;
              priming <= 1'b1;
              row     <= row + 16'd1;
              addr    <= row_addr;
              we      <= 1'b0;
            end
          end else if (col + 16'd1 == W_LAST) begin
            // Last column needs no fetch: write again on the next cycle.
            col   <= col + 16'd1;
            addr  <= addr + 16'd1;
            dataW <= out_word;
          end else begin
            col   <= col + 16'd1;
            state <= ST_R0;
            addr  <= row_addr - W + col + 16'd2;
            we    <= 1'b0;
          end
        end
        ST_DONE: begin
          if (!start) begin
            state  <= ST_IDLE;
            finish <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
